// File: rtl/edf_pkg.sv
// Shared types and helpers for the EDF preemption sequencer.
package edf_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    ACK  = 2'd2,
    HOLD = 2'd3
  } state_e;

  // Widest deadline the helpers handle; instances use their own low DlWidth bits.
  localparam int unsigned DlMaxWidth = 64;

  typedef struct packed {
    logic [DlMaxWidth-1:0] dl;
  } entry_t;

  // True when a is strictly earlier than b on a w-bit wrapping timeline.
  // The low w bits of the 64-bit difference equal the w-bit difference, so
  // bit w-1 is the sign of the wrap-safe comparison.
  function automatic logic dl_earlier(input entry_t a, input entry_t b,
                                      input int unsigned w);
    logic [DlMaxWidth-1:0] diff;
    diff = a.dl - b.dl;
    return |(diff & (DlMaxWidth'(1) << (w - 1)));
  endfunction

endpackage

// File: rtl/edf_nest_stack.sv
// LIFO of absolute deadlines for nested (preempted) handlers.
module edf_nest_stack #(
  parameter  int unsigned MaxNest    = 4,
  parameter  int unsigned DlWidth    = 24,
  localparam int unsigned DepthWidth = $clog2(MaxNest + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [DlWidth-1:0]    push_dl_i,
  output logic [DlWidth-1:0]    top_o,
  output logic [DepthWidth-1:0] depth_o,
  output logic                  full_o,
  output logic                  empty_o
);

  logic [DlWidth-1:0]    mem_q [MaxNest];
  logic [DlWidth-1:0]    mem_d [MaxNest];
  logic [DepthWidth-1:0] depth_q, depth_d;
  logic [DepthWidth-1:0] depth_after_pop;
  logic                  do_pop, do_push;

  assign empty_o = (depth_q == '0);
  assign full_o  = (depth_q == DepthWidth'(MaxNest));
  assign depth_o = depth_q;

  // Pop is applied first so a simultaneous push replaces the old top.
  always_comb begin
    do_pop          = pop_i & ~empty_o;
    depth_after_pop = depth_q - DepthWidth'(do_pop);
    do_push         = push_i & (depth_after_pop != DepthWidth'(MaxNest));
    depth_d         = depth_after_pop + DepthWidth'(do_push);
    mem_d           = mem_q;
    for (int unsigned i = 0; i < MaxNest; i++) begin
      if (do_push && (DepthWidth'(i) == depth_after_pop)) mem_d[i] = push_dl_i;
    end
  end

  // Top-of-stack read; zero when empty.
  always_comb begin
    top_o = '0;
    for (int unsigned i = 0; i < MaxNest; i++) begin
      if (DepthWidth'(i + 1) == depth_q) top_o = mem_q[i];
    end
  end

  // Stack storage and depth register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      depth_q <= '0;
      for (int unsigned i = 0; i < MaxNest; i++) mem_q[i] <= '0;
    end else begin
      depth_q <= depth_d;
      mem_q   <= mem_d;
    end
  end

endmodule

// File: rtl/edf_preempt_ctrl.sv
// Forwards the EDF controller's winner to the core when it preempts the
// running handler, runs the claim handshake and tracks nesting.
module edf_preempt_ctrl
  import edf_pkg::*;
#(
  parameter  int unsigned NrIrqs     = 4,
  parameter  int unsigned TsWidth    = 24,
  parameter  int unsigned TsClip     = 0,
  parameter  int unsigned MaxNest    = 4,
  localparam int unsigned IdWidth    = $clog2(NrIrqs),
  localparam int unsigned DlWidth    = TsWidth + TsClip,
  localparam int unsigned DepthWidth = $clog2(MaxNest + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [63:0]           mtime_i,
  input  logic                  irq_valid_i,
  input  logic [IdWidth-1:0]    irq_id_i,
  input  logic [DlWidth-1:0]    irq_dl_i,
  output logic                  irq_ack_o,
  output logic [IdWidth-1:0]    irq_id_o,
  output logic                  core_irq_o,
  output logic [IdWidth-1:0]    core_irq_id_o,
  output logic [DlWidth-1:0]    core_irq_dl_o,
  input  logic                  core_ack_i,
  input  logic                  core_complete_i,
  output logic [DepthWidth-1:0] depth_o,
  output logic [DlWidth-1:0]    thr_dl_o,
  output logic                  err_o
);

  state_e             state_q, state_d;
  logic [IdWidth-1:0] id_q, id_d;
  logic [DlWidth-1:0] dl_q, dl_d;
  logic               err_q, err_d;

  logic [DlWidth-1:0] cand_abs;
  logic [DlWidth-1:0] thr_dl;
  logic               st_full, st_empty;
  logic               preempt, qualify;
  entry_t             cand_e, thr_e;

  if (DlWidth < 64) begin : g_unused_mtime
    logic unused_mtime;
    assign unused_mtime = ^mtime_i[63:DlWidth];
  end

  edf_nest_stack #(
    .MaxNest (MaxNest),
    .DlWidth (DlWidth)
  ) u_stack (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .push_i    (state_q == ACK),
    .pop_i     (core_complete_i),
    .push_dl_i (dl_q),
    .top_o     (thr_dl),
    .depth_o   (depth_o),
    .full_o    (st_full),
    .empty_o   (st_empty)
  );

  // Candidate absolute deadline and the preemption qualification.
  always_comb begin
    cand_abs   = irq_dl_i + mtime_i[DlWidth-1:0];
    cand_e     = '0;
    thr_e      = '0;
    cand_e.dl  = DlMaxWidth'(cand_abs);
    thr_e.dl   = DlMaxWidth'(thr_dl);
    preempt    = dl_earlier(cand_e, thr_e, DlWidth);
    qualify    = irq_valid_i & (st_empty | preempt) & ~st_full;
  end

  // Handshake sequencing and request latching.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    dl_d    = dl_q;
    err_d   = err_q | (core_complete_i & st_empty);
    case (state_q)
      IDLE: begin
        if (qualify) begin
          id_d    = irq_id_i;
          dl_d    = cand_abs;
          state_d = REQ;
        end
      end
      REQ: begin
        if (core_ack_i) begin
          state_d = ACK;
        end else if (!qualify) begin
          state_d = IDLE;
        end else if (irq_id_i != id_q) begin
          id_d = irq_id_i;
          dl_d = cand_abs;
        end
      end
      ACK:     state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State, latched request and sticky error registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      id_q    <= '0;
      dl_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      dl_q    <= dl_d;
      err_q   <= err_d;
    end
  end

  assign core_irq_o    = (state_q == REQ);
  assign core_irq_id_o = core_irq_o ? id_q : '0;
  assign core_irq_dl_o = core_irq_o ? dl_q : '0;
  assign irq_ack_o     = (state_q == ACK);
  assign irq_id_o      = irq_ack_o ? id_q : '0;
  assign thr_dl_o      = thr_dl;
  assign err_o         = err_q;

endmodule

// File: tb/tb_edf_preempt_ctrl.sv
// Directed bench: instance A uses default sizing, instance B uses an 8-bit
// timeline and two-deep nesting for the wrap and full-stack cases.
module tb_edf_preempt_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] mtime;
  logic        irq_valid;
  logic [1:0]  irq_id;
  logic [23:0] irq_dl;
  logic        core_ack;
  logic        core_complete;

  logic        a_ack, a_irq, a_err;
  logic [1:0]  a_ack_id, a_irq_id;
  logic [23:0] a_irq_dl, a_thr;
  logic [2:0]  a_depth;

  logic        b_ack, b_irq, b_err;
  logic [1:0]  b_ack_id, b_irq_id;
  logic [7:0]  b_irq_dl, b_thr;
  logic [1:0]  b_depth;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  edf_preempt_ctrl u_a (
    .clk_i(clk), .rst_ni(rst_n), .mtime_i(mtime),
    .irq_valid_i(irq_valid), .irq_id_i(irq_id), .irq_dl_i(irq_dl),
    .irq_ack_o(a_ack), .irq_id_o(a_ack_id),
    .core_irq_o(a_irq), .core_irq_id_o(a_irq_id), .core_irq_dl_o(a_irq_dl),
    .core_ack_i(core_ack), .core_complete_i(core_complete),
    .depth_o(a_depth), .thr_dl_o(a_thr), .err_o(a_err)
  );

  edf_preempt_ctrl #(.TsWidth(8), .MaxNest(2)) u_b (
    .clk_i(clk), .rst_ni(rst_n), .mtime_i(mtime),
    .irq_valid_i(irq_valid), .irq_id_i(irq_id), .irq_dl_i(irq_dl[7:0]),
    .irq_ack_o(b_ack), .irq_id_o(b_ack_id),
    .core_irq_o(b_irq), .core_irq_id_o(b_irq_id), .core_irq_dl_o(b_irq_dl),
    .core_ack_i(core_ack), .core_complete_i(core_complete),
    .depth_o(b_depth), .thr_dl_o(b_thr), .err_o(b_err)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int unsigned n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    rst_n = 1'b0; mtime = '0; irq_valid = 1'b0; irq_id = '0; irq_dl = '0;
    core_ack = 1'b0; core_complete = 1'b0;
    #12;
    check("rst_irq",   64'(a_irq),    64'd0);
    check("rst_ack",   64'(a_ack),    64'd0);
    check("rst_depth", 64'(a_depth),  64'd0);
    check("rst_thr",   64'(a_thr),    64'd0);
    check("rst_err",   64'(a_err),    64'd0);
    check("rst_dl",    64'(a_irq_dl), 64'd0);
    step; rst_n = 1'b1;

    // Single IRQ: abs = 100 + 50
    mtime = 64'd100; irq_valid = 1'b1; irq_id = 2'd2; irq_dl = 24'd50;
    step;
    check("s1_req",    64'(a_irq),    64'd1);
    check("s1_req_id", 64'(a_irq_id), 64'd2);
    check("s1_req_dl", 64'(a_irq_dl), 64'd150);
    core_ack = 1'b1; step;
    check("s1_ack",    64'(a_ack),    64'd1);
    check("s1_ack_id", 64'(a_ack_id), 64'd2);
    check("s1_irq_lo", 64'(a_irq),    64'd0);
    core_ack = 1'b0; step;
    check("s1_ack_lo", 64'(a_ack),    64'd0);
    check("s1_depth",  64'(a_depth),  64'd1);
    check("s1_thr",    64'(a_thr),    64'd150);
    step(3);
    check("s1_tie_noreq", 64'(a_irq), 64'd0);

    // Preemption: abs 130 < 150
    mtime = 64'd110; irq_id = 2'd1; irq_dl = 24'd20;
    step;
    check("s2_req",    64'(a_irq),    64'd1);
    check("s2_req_dl", 64'(a_irq_dl), 64'd130);
    core_ack = 1'b1; step;
    check("s2_ack_id", 64'(a_ack_id), 64'd1);
    core_ack = 1'b0; step;
    check("s2_depth",  64'(a_depth),  64'd2);
    check("s2_thr",    64'(a_thr),    64'd130);
    irq_id = 2'd3; irq_dl = 24'd60; step(3);
    check("s2_later_noreq", 64'(a_irq), 64'd0);
    irq_dl = 24'd20; step(3);
    check("s2_equal_noreq", 64'(a_irq), 64'd0);

    // Re-latch on id change, then withdraw
    irq_id = 2'd0; irq_dl = 24'd10; step;
    check("wd_req",     64'(a_irq),    64'd1);
    check("wd_req_dl",  64'(a_irq_dl), 64'd120);
    irq_id = 2'd3; irq_dl = 24'd5; step;
    check("relatch_id", 64'(a_irq_id), 64'd3);
    check("relatch_dl", 64'(a_irq_dl), 64'd115);
    irq_valid = 1'b0; step;
    check("wd_irq_lo",  64'(a_irq),   64'd0);
    check("wd_no_ack",  64'(a_ack),   64'd0);
    step;
    check("wd_no_ack2", 64'(a_ack),   64'd0);
    check("wd_depth",   64'(a_depth), 64'd2);

    // Reset while in REQ
    irq_valid = 1'b1; irq_id = 2'd0; irq_dl = 24'd10; step;
    check("rq_req", 64'(a_irq), 64'd1);
    rst_n = 1'b0; #1;
    check("rq_irq_async", 64'(a_irq),    64'd0);
    check("rq_dl_async",  64'(a_irq_dl), 64'd0);
    check("rq_depth",     64'(a_depth),  64'd0);
    check("rq_thr",       64'(a_thr),    64'd0);
    irq_valid = 1'b0; step; rst_n = 1'b1; step;
    check("rq_no_ack", 64'(a_ack), 64'd0);
    step;
    check("rq_no_ack2", 64'(a_ack), 64'd0);
    check("rq_irq_lo",  64'(a_irq), 64'd0);

    // Reset while in ACK
    irq_valid = 1'b1; irq_id = 2'd1; irq_dl = 24'd50; step;
    core_ack = 1'b1; step;
    check("ra_ack", 64'(a_ack), 64'd1);
    core_ack = 1'b0; irq_valid = 1'b0; rst_n = 1'b0; #1;
    check("ra_ack_async",    64'(a_ack),    64'd0);
    check("ra_ack_id_async", 64'(a_ack_id), 64'd0);
    step; rst_n = 1'b1; step;
    check("ra_no_ack", 64'(a_ack),   64'd0);
    check("ra_depth",  64'(a_depth), 64'd0);
    check("ra_err",    64'(a_err),   64'd0);

    // Wrap-around on the 8-bit instance: top = 0xE0 + 0x10 = 0xF0
    mtime = 64'hE0; irq_valid = 1'b1; irq_id = 2'd2; irq_dl = 24'h10; step;
    check("w_req",    64'(b_irq),    64'd1);
    check("w_req_id", 64'(b_irq_id), 64'd2);
    check("w_req_dl", 64'(b_irq_dl), 64'hF0);
    core_ack = 1'b1; step;
    check("w_ack",    64'(b_ack),    64'd1);
    check("w_ack_id", 64'(b_ack_id), 64'd2);
    core_ack = 1'b0; step;
    check("w_depth", 64'(b_depth), 64'd1);
    check("w_thr",   64'(b_thr),   64'hF0);
    mtime = 64'hE8; irq_dl = 24'h20; step(3);
    check("w_abs08_noreq", 64'(b_irq), 64'd0);
    irq_dl = 24'h04; step;
    check("w_absEC_req", 64'(b_irq),    64'd1);
    check("w_absEC_dl",  64'(b_irq_dl), 64'hEC);
    core_ack = 1'b1; step; core_ack = 1'b0; step;
    check("f_depth2", 64'(b_depth), 64'd2);
    check("f_thr2",   64'(b_thr),   64'hEC);

    // Full stack blocks an earlier IRQ (abs 0xE9) until a pop
    irq_id = 2'd1; irq_dl = 24'h01; step(3);
    check("f_blocked", 64'(b_irq), 64'd0);
    core_complete = 1'b1; step; core_complete = 1'b0;
    check("f_pop_depth", 64'(b_depth), 64'd1);
    check("f_pop_thr",   64'(b_thr),   64'hF0);
    check("f_pop_err",   64'(b_err),   64'd0);
    step;
    check("f_req_after_pop", 64'(b_irq),    64'd1);
    check("f_req_dl",        64'(b_irq_dl), 64'hE9);
    irq_valid = 1'b0; step;
    check("f_withdrawn", 64'(b_irq), 64'd0);
    core_complete = 1'b1; step(3); core_complete = 1'b0;
    check("e_depth0", 64'(b_depth), 64'd0);
    check("e_err",    64'(b_err),   64'd1);
    step;
    check("e_err_sticky", 64'(b_err), 64'd1);
    check("e_thr0",       64'(b_thr), 64'd0);

    // Completion coinciding with the ACK push replaces the top
    rst_n = 1'b0; step; rst_n = 1'b1;
    mtime = 64'd100; irq_valid = 1'b1; irq_id = 2'd2; irq_dl = 24'd50; step;
    core_ack = 1'b1; step; core_ack = 1'b0; step;
    check("c_depth1", 64'(a_depth), 64'd1);
    mtime = 64'd110; irq_id = 2'd1; irq_dl = 24'd20; step(2);
    check("c_req", 64'(a_irq), 64'd1);
    core_ack = 1'b1; step; core_ack = 1'b0;
    check("c_in_ack", 64'(a_ack), 64'd1);
    core_complete = 1'b1; irq_valid = 1'b0; step; core_complete = 1'b0;
    check("c_depth_same", 64'(a_depth), 64'd1);
    check("c_thr_new",    64'(a_thr),   64'd130);
    check("c_err",        64'(a_err),   64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/edf_preempt_ctrl.md
Name: edf_preempt_ctrl

Overview:
- Sequencer between the EDF interrupt controller and the core.
- Watches the controller's arbitration winner and forwards it to the core only if its absolute deadline is strictly earlier than the currently running handler's.
- Runs the claim handshake: core take → ack/claim pulse back to the controller.
- Keeps a LIFO of nested (preempted) handler deadlines, popped on handler completion.

Parameters:
- NrIrqs, 4, number of interrupt lines; IdWidth = $clog2(NrIrqs) (localparam).
- TsWidth, 24, controller timestamp width.
- TsClip, 0, controller timestamp clip; DlWidth = TsWidth+TsClip (localparam).
- MaxNest, 4, maximum nesting depth (stack entries); DepthWidth = $clog2(MaxNest+1) (localparam).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous active-low reset
- mtime_i  in  64  machine timer
- irq_valid_i  in  1  controller has an enabled, pending winner
- irq_id_i  in  IdWidth  winner line id
- irq_dl_i  in  DlWidth  winner relative deadline (time to deadline)
- irq_ack_o  out  1  claim pulse to controller
- irq_id_o  out  IdWidth  id being claimed; valid with irq_ack_o
- core_irq_o  out  1  interrupt request to core
- core_irq_id_o  out  IdWidth  requested id
- core_irq_dl_o  out  DlWidth  requested absolute deadline
- core_ack_i  in  1  core takes the request (honoured only while core_irq_o=1)
- core_complete_i  in  1  core finished current handler (1-cycle pulse)
- depth_o  out  DepthWidth  current nesting depth
- thr_dl_o  out  DlWidth  absolute deadline at stack top; 0 when depth_o=0
- err_o  out  1  sticky: completion seen at depth 0

Behaviour:
- Reset: FSM=IDLE, stack empty, every output 0.
- Clock and reset: single clock clk_i; reset is asynchronous, active-low (rst_ni).
- Absolute deadline: cand_abs = irq_dl_i + mtime_i[DlWidth-1:0], mod 2^DlWidth.
- Preemption test: preempt = $signed(cand_abs - thr_dl) < 0, computed in DlWidth bits (wrap-safe). Ties do not preempt.
- qualify = irq_valid_i & (depth==0 | preempt) & (depth<MaxNest).
- FSM states:
  - IDLE: if qualify, latch id/cand_abs → REQ.
  - REQ: core_irq_o=1 with latched id/dl.
    - core_ack_i → ACK.
    - Else if !qualify → IDLE (request withdrawn, no ack).
    - Else if irq_id_i differs from latched id → re-latch id/dl, stay in REQ.
  - ACK: irq_ack_o=1, irq_id_o=latched id for exactly one cycle; push latched dl onto the stack → HOLD.
  - HOLD: one cycle with no request, letting the controller's ip clear propagate → IDLE.
- Output timing: core_irq_o is registered. It asserts the cycle after qualify and falls the cycle after core_ack_i. irq_ack_o asserts the cycle after core_ack_i.
- core_complete_i is honoured in every state: pop if depth>0; at depth 0, ignore the pop and set err_o (sticky until reset).
- Complete coinciding with the ACK push: pop first, then push (depth unchanged, top replaced).
- Complete while in REQ: re-evaluate qualify against the new top on the next cycle.
- Full stack (depth==MaxNest): qualify=0 and no request is issued. Pending interrupts wait until a pop.
- Reset mid-handshake: all state is dropped. No ack is issued for an un-acked request.

Decomposition:
- Package edf_pkg:
  - state enum {IDLE, REQ, ACK, HOLD};
  - entry typedef (DlWidth deadline);
  - wrap-aware "earlier" compare function.
- Sub-module edf_nest_stack:
  - parameterised LIFO (MaxNest x DlWidth);
  - push/pop with pop-before-push ordering;
  - top, depth, full, empty outputs.

Test Plan:
- Single IRQ: mtime=100, valid, id=2, dl=50.
  - core_irq_o rises next cycle with id 2, dl 150.
  - core_ack_i → irq_ack_o one pulse with irq_id_o=2; depth_o=1, thr_dl_o=150.
- Preemption: top=150, mtime=110, winner id 1 with dl=20 (abs 130).
  - Forwarded and acked; depth 2, thr 130.
  - Then dl=60 (abs 170): no core_irq_o.
  - Equal abs 130: no core_irq_o.
- Wrap-around, TsWidth=8: top=0xF0, mtime=0xE8, dl=0x20 (abs 0x08) → not earlier, no request; dl=0x04 (abs 0xEC) → request.
- Withdraw: request up, controller drops irq_valid_i before core_ack_i → core_irq_o falls, irq_ack_o never pulses, depth unchanged.
- Full and completion: MaxNest=2, two acks, a third earlier IRQ is blocked. core_complete_i → depth 1 and the third IRQ is requested. Three further completes → depth 0 and err_o=1.
- Reset in REQ/ACK: rst_ni low → all outputs 0 asynchronously, stack empty, no stray irq_ack_o after release.
